banked_memory_buffer: RTL and testbench

- Parametrised successor to the PE-array memory buffer: N_BANK independent single-port-read/single-port-write banks shared between a host port (one bank per access, optional broadcast write) and a PE port (all banks in parallel).
- Adds registered read data with valid strobes, a handshaked mode-switch FSM that drains in-flight reads, per-bank PE write masking, and sticky bank-index error detection.
- Sits between the load/store controller (host port) and the PE array (PE port).

---
 rtl/banked_memory_buffer.sv | 228 ++++++++++++++++++++++
 tb/tb_banked_memory_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_memory_buffer.sv
// banked_memory_buffer: N_BANK banks shared by a host port and a PE port.
// Build option: define BANKED_BUF_WR_FWD_EN for same-cycle write-to-read bypass.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   mode_req_valid    mode-change request strobe
//   mode_req          requested mode (0 host, 1 PE)
//   mode, mode_ack    current mode; one-cycle ack when the request is in effect
//   host_rd_*         one-bank read; data and valid arrive two cycles later
//   host_wr_*         one-bank write, or every bank when host_wr_bcast is set
//   pe_rd_*           all-bank read at a shared address, packed output
//   pe_wr_*           all-bank write at a shared address, per-bank mask
//   bank_err          sticky flag for a host bank index >= N_BANK
module banked_memory_buffer #(
  parameter int N_BANK = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int BANK_W = $clog2(N_BANK)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode_req_valid,
  input  logic                     mode_req,
  output logic                     mode_ack,
  output logic                     mode,
  input  logic                     host_rd_en,
  input  logic [BANK_W-1:0]        host_rd_bank,
  input  logic [ADDR_W-1:0]        host_rd_addr,
  output logic [DATA_W-1:0]        host_rd_data,
  output logic                     host_rd_valid,
  input  logic                     host_wr_en,
  input  logic                     host_wr_bcast,
  input  logic [BANK_W-1:0]        host_wr_bank,
  input  logic [ADDR_W-1:0]        host_wr_addr,
  input  logic [DATA_W-1:0]        host_wr_data,
  input  logic                     pe_rd_en,
  input  logic [ADDR_W-1:0]        pe_rd_addr,
  output logic [DATA_W*N_BANK-1:0] pe_rd_data,
  output logic                     pe_rd_valid,
  input  logic                     pe_wr_en,
  input  logic [N_BANK-1:0]        pe_wr_mask,
  input  logic [ADDR_W-1:0]        pe_wr_addr,
  input  logic [DATA_W*N_BANK-1:0] pe_wr_data,
  output logic                     bank_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [BANK_W:0] NB =
    (BANK_W+1)'(N_BANK);

  typedef enum logic [1:0] {
    S_HOST,
    S_PE,
    S_DRAIN
  } state_t;

  state_t state;
  state_t state_n;

  logic tgt_q;
  logic drain_cnt;
  logic mode_q;
  logic ack_q;

  logic req_same;
  logic req_chg;
  logic leave;
  logic host_act;
  logic pe_act;

  logic host_rd_ok;
  logic host_wr_ok;
  logic host_rd_go;
  logic host_wr_go;
  logic pe_rd_go;
  logic pe_wr_go;
  logic rd_any;
  logic err_set;

  logic [DATA_W*N_BANK-1:0] bank_rd;
  logic [DATA_W-1:0]        host_sel;

  logic              h_v1;
  logic [BANK_W-1:0] h_b1;
  logic              p_v1;

  assign req_same = mode_req_valid
                 && (state != S_DRAIN)
                 && (mode_req == mode_q);
  assign req_chg  = mode_req_valid
                 && (state != S_DRAIN)
                 && (mode_req != mode_q);
  // Two drain cycles: cnt 0 then 1, exit at the end of the second.
  assign leave    = (state == S_DRAIN) && drain_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HOST;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_HOST:  if (req_chg) state_n = S_DRAIN;
      S_PE:    if (req_chg) state_n = S_DRAIN;
      S_DRAIN: if (drain_cnt)
                 state_n = tgt_q ? S_PE : S_HOST;
      default: state_n = S_HOST;
    endcase
  end

  always_comb begin
    host_act = 1'b0;
    pe_act   = 1'b0;
    unique case (state)
      S_HOST:  host_act = 1'b1;
      S_PE:    pe_act   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q     <= 1'b0;
      drain_cnt <= 1'b0;
      mode_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      if (req_chg) tgt_q <= mode_req;
      drain_cnt <= (state == S_DRAIN)
                 ? ~drain_cnt : 1'b0;
      if (leave) mode_q <= tgt_q;
      ack_q <= req_same | leave;
    end
  end

  assign mode     = mode_q;
  assign mode_ack = ack_q;

  assign host_rd_ok = {1'b0, host_rd_bank} < NB;
  assign host_wr_ok = {1'b0, host_wr_bank} < NB;

  assign host_rd_go = host_act && host_rd_en
                   && host_rd_ok;
  assign host_wr_go = host_act && host_wr_en
                   && (host_wr_bcast || host_wr_ok);
  assign pe_rd_go   = pe_act && pe_rd_en;
  assign pe_wr_go   = pe_act && pe_wr_en;
  assign rd_any     = host_rd_go || pe_rd_go;

  assign err_set = host_act
                && ((host_rd_en && !host_rd_ok)
                 || (host_wr_en && !host_wr_bcast
                     && !host_wr_ok));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bank_err <= 1'b0;
    else if (err_set) bank_err <= 1'b1;
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] wd;

    always_comb begin
      we = (host_wr_go
            && (host_wr_bcast
                || host_wr_bank == BANK_W'(b)))
        || (pe_wr_go && pe_wr_mask[b]);
      wa = pe_act ? pe_wr_addr : host_wr_addr;
      ra = pe_act ? pe_rd_addr : host_rd_addr;
      wd = pe_act ? pe_wr_data[b*DATA_W +: DATA_W]
                  : host_wr_data;
    end

    always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk) begin
      if (rd_any) begin
`ifdef BANKED_BUF_WR_FWD_EN
        if (we && wa == ra) rd_q <= wd;
        else                rd_q <= mem[ra];
`else
        rd_q <= mem[ra];
`endif
      end
    end

    assign bank_rd[b*DATA_W +: DATA_W] = rd_q;
  end

  always_comb begin
    host_sel = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (h_b1 == BANK_W'(b))
        host_sel = bank_rd[b*DATA_W +: DATA_W];
    end
  end

  // Output stage; keeps running through drain so
  // reads accepted earlier still deliver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_v1          <= 1'b0;
      h_b1          <= '0;
      p_v1          <= 1'b0;
      host_rd_valid <= 1'b0;
      host_rd_data  <= '0;
      pe_rd_valid   <= 1'b0;
      pe_rd_data    <= '0;
    end else begin
      h_v1          <= host_rd_go;
      p_v1          <= pe_rd_go;
      if (host_rd_go) h_b1 <= host_rd_bank;
      host_rd_valid <= h_v1;
      pe_rd_valid   <= p_v1;
      if (h_v1) host_rd_data <= host_sel;
      if (p_v1) pe_rd_data   <= bank_rd;
    end
  end

endmodule

// File: tb/tb_banked_memory_buffer.sv
// tb_banked_memory_buffer: directed bench for banked_memory_buffer.
// Runs an 8-bank instance and a 6-bank instance for bank-index errors.
module tb_banked_memory_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         mode_req_valid;
  logic         mode_req;
  logic         mode_ack;
  logic         mode;
  logic         host_rd_en;
  logic [2:0]   host_rd_bank;
  logic [9:0]   host_rd_addr;
  logic [15:0]  host_rd_data;
  logic         host_rd_valid;
  logic         host_wr_en;
  logic         host_wr_bcast;
  logic [2:0]   host_wr_bank;
  logic [9:0]   host_wr_addr;
  logic [15:0]  host_wr_data;
  logic         pe_rd_en;
  logic [9:0]   pe_rd_addr;
  logic [127:0] pe_rd_data;
  logic         pe_rd_valid;
  logic         pe_wr_en;
  logic [7:0]   pe_wr_mask;
  logic [9:0]   pe_wr_addr;
  logic [127:0] pe_wr_data;
  logic         bank_err;

  logic         r6_en;
  logic [2:0]   r6_bank;
  logic [9:0]   r6_addr;
  logic [15:0]  r6_data;
  logic         r6_valid;
  logic         w6_en;
  logic [2:0]   w6_bank;
  logic [9:0]   w6_addr;
  logic [15:0]  w6_data;
  logic         ack6;
  logic         mode6;
  logic [95:0]  pe6_data;
  logic         pe6_valid;
  logic         err6;

  banked_memory_buffer u_dut (
    .clk(clk), .rst(rst),
    .mode_req_valid(mode_req_valid),
    .mode_req(mode_req),
    .mode_ack(mode_ack), .mode(mode),
    .host_rd_en(host_rd_en),
    .host_rd_bank(host_rd_bank),
    .host_rd_addr(host_rd_addr),
    .host_rd_data(host_rd_data),
    .host_rd_valid(host_rd_valid),
    .host_wr_en(host_wr_en),
    .host_wr_bcast(host_wr_bcast),
    .host_wr_bank(host_wr_bank),
    .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data),
    .pe_rd_en(pe_rd_en),
    .pe_rd_addr(pe_rd_addr),
    .pe_rd_data(pe_rd_data),
    .pe_rd_valid(pe_rd_valid),
    .pe_wr_en(pe_wr_en),
    .pe_wr_mask(pe_wr_mask),
    .pe_wr_addr(pe_wr_addr),
    .pe_wr_data(pe_wr_data),
    .bank_err(bank_err)
  );

  banked_memory_buffer #(.N_BANK(6)) u_dut6 (
    .clk(clk), .rst(rst),
    .mode_req_valid(1'b0),
    .mode_req(1'b0),
    .mode_ack(ack6), .mode(mode6),
    .host_rd_en(r6_en),
    .host_rd_bank(r6_bank),
    .host_rd_addr(r6_addr),
    .host_rd_data(r6_data),
    .host_rd_valid(r6_valid),
    .host_wr_en(w6_en),
    .host_wr_bcast(1'b0),
    .host_wr_bank(w6_bank),
    .host_wr_addr(w6_addr),
    .host_wr_data(w6_data),
    .pe_rd_en(1'b0),
    .pe_rd_addr(10'd0),
    .pe_rd_data(pe6_data),
    .pe_rd_valid(pe6_valid),
    .pe_wr_en(1'b0),
    .pe_wr_mask(6'd0),
    .pe_wr_addr(10'd0),
    .pe_wr_data(96'd0),
    .bank_err(err6)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mode_req_valid = 1'b0;
    mode_req       = 1'b0;
    host_rd_en     = 1'b0;
    host_rd_bank   = '0;
    host_rd_addr   = '0;
    host_wr_en     = 1'b0;
    host_wr_bcast  = 1'b0;
    host_wr_bank   = '0;
    host_wr_addr   = '0;
    host_wr_data   = '0;
    pe_rd_en       = 1'b0;
    pe_rd_addr     = '0;
    pe_wr_en       = 1'b0;
    pe_wr_mask     = '0;
    pe_wr_addr     = '0;
    pe_wr_data     = '0;
    r6_en          = 1'b0;
    r6_bank        = '0;
    r6_addr        = '0;
    w6_en          = 1'b0;
    w6_bank        = '0;
    w6_addr        = '0;
    w6_data        = '0;
  endtask

  task automatic hwr(input int b, input int a,
                     input logic [15:0] d,
                     input logic bc);
    host_wr_en    = 1'b1;
    host_wr_bank  = 3'(b);
    host_wr_addr  = 10'(a);
    host_wr_data  = d;
    host_wr_bcast = bc;
    tick();
    host_wr_en    = 1'b0;
    host_wr_bcast = 1'b0;
  endtask

  task automatic hrd(input int b, input int a);
    host_rd_en   = 1'b1;
    host_rd_bank = 3'(b);
    host_rd_addr = 10'(a);
    tick();
    host_rd_en   = 1'b0;
  endtask

  task automatic prd(input int a);
    pe_rd_en   = 1'b1;
    pe_rd_addr = 10'(a);
    tick();
    pe_rd_en   = 1'b0;
  endtask

  task automatic req(input logic m);
    mode_req_valid = 1'b1;
    mode_req       = m;
    tick();
    mode_req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [127:0] pexp;
  logic [15:0]  oldv;

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_mode", mode, 0);
    chk("rst_ack", mode_ack, 0);
    chk("rst_hv", host_rd_valid, 0);
    chk("rst_pv", pe_rd_valid, 0);
    chk("rst_hd", host_rd_data, 0);
    chk("rst_pd", pe_rd_data, 0);
    chk("rst_err", bank_err, 0);
    chk("rst_err6", err6, 0);

    // 6-bank instance: bank 7 is out of range
    r6_en = 1'b1; r6_bank = 3'd7; r6_addr = 10'd1;
    tick();
    r6_en = 1'b0;
    chk("e6_v1", r6_valid, 0);
    chk("e6_err", err6, 1);
    tick();
    chk("e6_v2", r6_valid, 0);
    w6_en = 1'b1; w6_bank = 3'd5;
    w6_addr = 10'd1; w6_data = 16'h0A0A;
    tick();
    w6_en = 1'b0;
    r6_en = 1'b1; r6_bank = 3'd5; r6_addr = 10'd1;
    tick();
    r6_en = 1'b0;
    tick();
    chk("e6_ok_v", r6_valid, 1);
    chk("e6_ok_d", r6_data, 16'h0A0A);
    chk("e6_hold", err6, 1);

    // host write then read, 2-cycle latency
    hwr(3, 5, 16'h1234, 1'b0);
    hrd(3, 5);
    chk("h_lat1", host_rd_valid, 0);
    tick();
    chk("h_v", host_rd_valid, 1);
    chk("h_d", host_rd_data, 16'h1234);
    tick();
    chk("h_once", host_rd_valid, 0);

    // broadcast write, then switch to PE
    hwr(2, 7, 16'hBEEF, 1'b1);
    req(1'b1);
    chk("sw_ack1", mode_ack, 0);
    chk("sw_mode1", mode, 0);
    tick();
    chk("sw_ack2", mode_ack, 0);
    tick();
    chk("sw_ack3", mode_ack, 1);
    chk("sw_mode3", mode, 1);
    tick();
    chk("sw_ack4", mode_ack, 0);
    chk("sw_mode4", mode, 1);

    prd(7);
    chk("bc_lat", pe_rd_valid, 0);
    tick();
    chk("bc_v", pe_rd_valid, 1);
    chk("bc_d", pe_rd_data, {8{16'hBEEF}});
    tick();
    chk("bc_once", pe_rd_valid, 0);

    // host port ignored in PE mode
    hrd(3, 5);
    tick();
    chk("pe_hign", host_rd_valid, 0);

    // same-mode request acks next cycle
    req(1'b1);
    chk("same_ack", mode_ack, 1);
    chk("same_mode", mode, 1);
    tick();
    chk("same_ack0", mode_ack, 0);

    // masked PE write
    pe_wr_en   = 1'b1;
    pe_wr_addr = 10'd2;
    pe_wr_mask = 8'hFF;
    for (int i = 0; i < 8; i++)
      pe_wr_data[i*16 +: 16] = 16'(16'h00A0 + i);
    tick();
    pe_wr_mask = 8'b1010_0101;
    for (int i = 0; i < 8; i++)
      pe_wr_data[i*16 +: 16] = 16'(i + 1);
    tick();
    pe_wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (pe_wr_mask[i])
        pexp[i*16 +: 16] = 16'(i + 1);
      else
        pexp[i*16 +: 16] = 16'(16'h00A0 + i);
    end
    prd(2);
    tick();
    chk("mask_v", pe_rd_valid, 1);
    chk("mask_d", pe_rd_data, pexp);

    // PE read before switch to HOST; drain
    prd(2);
    req(1'b0);
    chk("dr_pv", pe_rd_valid, 1);
    chk("dr_pd", pe_rd_data, pexp);
    chk("dr_mode", mode, 1);
    pe_rd_en = 1'b1; pe_rd_addr = 10'd2;
    mode_req_valid = 1'b1; mode_req = 1'b1;
    tick();
    pe_rd_en = 1'b0;
    mode_req_valid = 1'b0;
    chk("dr_pv0", pe_rd_valid, 0);
    chk("dr_noack", mode_ack, 0);
    hrd(3, 5);
    chk("dr_ack", mode_ack, 1);
    chk("dr_m0", mode, 0);
    chk("dr_pign", pe_rd_valid, 0);
    tick();
    chk("dr_hign", host_rd_valid, 0);
    chk("dr_ack0", mode_ack, 0);
    tick();
    chk("dr_stay", mode, 0);
    chk("dr_ack00", mode_ack, 0);

    // host read before switch to PE
    hrd(3, 5);
    req(1'b1);
    chk("hd_v", host_rd_valid, 1);
    chk("hd_d", host_rd_data, 16'h1234);
    hrd(3, 5);
    chk("hd_v0", host_rd_valid, 0);
    tick();
    chk("hd_ack", mode_ack, 1);
    chk("hd_ign", host_rd_valid, 0);
    req(1'b0);
    tick();
    tick();
    chk("back_m0", mode, 0);

    // same-cycle write and read
    hwr(0, 0, 16'h1111, 1'b0);
    host_wr_en = 1'b1; host_wr_bank = 3'd0;
    host_wr_addr = 10'd0; host_wr_data = 16'h5555;
    hrd(0, 0);
    host_wr_en = 1'b0;
    tick();
`ifdef BANKED_BUF_WR_FWD_EN
    oldv = 16'h5555;
`else
    oldv = 16'h1111;
`endif
    chk("rw_v", host_rd_valid, 1);
    chk("rw_d", host_rd_data, oldv);
    hrd(0, 0);
    tick();
    chk("rw_new", host_rd_data, 16'h5555);
    chk("err8", bank_err, 0);

    // reset while draining
    host_rd_en = 1'b1; host_rd_bank = 3'd3;
    host_rd_addr = 10'd5;
    mode_req_valid = 1'b1; mode_req = 1'b1;
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("rd_hv", host_rd_valid, 0);
    chk("rd_mode", mode, 0);
    chk("rd_err6", err6, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_noack", mode_ack, 0);
      chk("rd_nohv", host_rd_valid, 0);
      tick();
    end
    chk("rd_m0", mode, 0);
    hrd(3, 5);
    tick();
    chk("rd_hostv", host_rd_valid, 1);
    chk("rd_keep", host_rd_data, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
